fetch_unit: RTL
===============

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 clk  in  1  system clock; all state SHALL update on its rising edge.
REQ-002 reset  in  1  SHALL be asynchronous and active-low: asserted (0) clears all state immediately; released synchronously to clk.
REQ-003 pc  in  64  current program counter value.
REQ-004 pc_en  out  1  enable to the program counter DFFs; 1 = PC loads its next value this edge.
REQ-005 flush  in  1  branch redirect; program counter select already points at the target.
REQ-006 stall  in  1  decode hazard; IF/ID contents SHALL be held.
REQ-007 imem_req_valid / imem_req_ready  out / in  1 / 1  instruction memory request handshake.
REQ-008 imem_req_addr  out  64  fetch address.
REQ-009 imem_rsp_valid  in  1  response strobe, one cycle, at least 1 cycle after the request is accepted.
REQ-010 imem_rsp_data  in  32  instruction word.
REQ-011 if_valid, if_pc[63:0], if_instr[31:0]  out  IF/ID pipeline register to decode.

Function
REQ-012 FSM states SHALL be IDLE, REQ, WAIT, HOLD; there SHALL be at most one outstanding request.
REQ-013 IDLE: one cycle after reset release -> REQ.
REQ-014 REQ: imem_req_valid=1 and imem_req_addr=pc; req_ready=1 -> WAIT, otherwise remain in REQ with address stable.
REQ-015 WAIT, rsp_valid=1, stall=0: if_pc<=request address, if_instr<=rsp_data, if_valid<=1, pc_en=1 for exactly that cycle -> REQ.
REQ-016 WAIT, rsp_valid=1, stall=1: response captured into a skid buffer, IF/ID unchanged -> HOLD; no response SHALL be lost.
REQ-017 HOLD: stall=0 -> skid contents loaded into IF/ID, pc_en=1 for one cycle -> REQ.
REQ-018 When stall=1 and no new instruction is loaded, IF/ID SHALL hold its values; when stall=0 and no response arrives, if_valid<=0 next edge.
REQ-019 flush (any state) SHALL: clear if_valid next edge; drive pc_en=1 that cycle; discard the skid buffer; go to REQ.
REQ-020 flush in WAIT before rsp_valid SHALL set a drop flag; the next rsp_valid is discarded, and no new request is issued until it arrives.
REQ-021 flush takes priority over stall and rsp_valid in the same cycle.
REQ-022 Fetch-to-if_valid latency SHALL be 1 cycle after rsp_valid.
REQ-023 pc_en SHALL be 0 in every cycle except those named in REQ-015/017/019.

Reset
REQ-024 On reset=0: state=IDLE, pc_en=0, imem_req_valid=0, imem_req_addr=0, if_valid=0, if_pc=0, if_instr=NOP, skid and drop flag cleared.
REQ-025 Reset mid-transaction SHALL abandon the outstanding request; a late rsp_valid after release SHALL be ignored while in IDLE.

Configuration
REQ-026 Macro FETCH_MISALIGN_CHECK_EN: when defined, pc[1:0]!=0 in REQ SHALL issue no request, load IF/ID with if_instr=NOP, and assert output misalign_err (1 bit, registered, with if_valid=1). pc_en SHALL NOT pulse; the block waits for flush.
REQ-027 Without the macro, there is no misalign_err port, and the address is sent unmodified.

Structure
REQ-028 Package cpu_pkg SHALL hold fetch_state_t, ADDR_W=64, INSTR_W=32, and NOP_INSTR=32'hD503201F.
REQ-029 IF/ID storage SHALL be a sub-module if_id_reg (load, hold, clear inputs); the FSM SHALL stay in fetch_unit.

Verification
REQ-030 pc=0x0, ready=1, rsp one cycle later with 0x8B020020 -> if_valid=1, if_pc=0x0, if_instr=0x8B020020, single pc_en pulse.
REQ-031 req_ready held 0 for 3 cycles at pc=0x10 -> imem_req_addr stays 0x10, pc_en=0 throughout.
REQ-032 stall=1 when rsp 0xAAAA0000 arrives, released 2 cycles later -> IF/ID unchanged during stall, then 0xAAAA0000 loaded, one pc_en pulse.
REQ-033 flush in WAIT, then rsp 0xDEAD0000 -> response dropped, if_valid=0, next request uses the redirected pc.
REQ-034 reset=0 asserted mid-WAIT -> all outputs at reset values immediately; a late rsp_valid is ignored.
REQ-035 With FETCH_MISALIGN_CHECK_EN, pc=0x6 -> no imem_req_valid, misalign_err=1, if_instr=NOP.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared fetch-stage types and constants.
package cpu_pkg;

  localparam int unsigned ADDR_W  = 64;
  localparam int unsigned INSTR_W = 32;

  localparam logic [INSTR_W-1:0] NOP_INSTR = 32'hD503201F;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    HOLD = 2'd3
  } fetch_state_t;

endpackage

// File: rtl/fetch_unit_if_id_reg.sv
// IF/ID pipeline register.
//   load  : capture load_pc/load_instr, mark valid
//   hold  : keep current contents
//   clear : drop valid (wins over load and hold)
//   none  : valid drops, pc/instr retained
module if_id_reg
  import cpu_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               load,
  input  logic               hold,
  input  logic               clear,
  input  logic [ADDR_W-1:0]  load_pc,
  input  logic [INSTR_W-1:0] load_instr,
  output logic               if_valid,
  output logic [ADDR_W-1:0]  if_pc,
  output logic [INSTR_W-1:0] if_instr
);

  logic               valid_q, valid_d;
  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic [INSTR_W-1:0] instr_q, instr_d;

  always_comb begin
    valid_d = valid_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    if (clear) begin
      valid_d = 1'b0;
    end else if (load) begin
      valid_d = 1'b1;
      pc_d    = load_pc;
      instr_d = load_instr;
    end else if (!hold) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_q <= 1'b0;
      pc_q    <= '0;
      instr_q <= NOP_INSTR;
    end else begin
      valid_q <= valid_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
    end
  end

  assign if_valid = valid_q;
  assign if_pc    = pc_q;
  assign if_instr = instr_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: single-outstanding imem request FSM feeding IF/ID.
// Ports: clk, reset (async, active-low), pc / pc_en (PC register interface),
//        flush, stall, imem_req_* / imem_rsp_* (instruction memory),
//        if_valid / if_pc / if_instr (to decode).
// Optional: FETCH_MISALIGN_CHECK_EN adds misalign_err and blocks misaligned fetches.
module fetch_unit
  import cpu_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic [ADDR_W-1:0]  pc,
  output logic               pc_en,
  input  logic               flush,
  input  logic               stall,
  output logic               imem_req_valid,
  input  logic               imem_req_ready,
  output logic [ADDR_W-1:0]  imem_req_addr,
  input  logic               imem_rsp_valid,
  input  logic [INSTR_W-1:0] imem_rsp_data,
  output logic               if_valid,
  output logic [ADDR_W-1:0]  if_pc,
  output logic [INSTR_W-1:0] if_instr
`ifdef FETCH_MISALIGN_CHECK_EN
  ,
  output logic               misalign_err
`endif
);

  fetch_state_t       state_q, state_d;
  logic               drop_q, drop_d;
  logic [INSTR_W-1:0] skid_q, skid_d;
  logic [ADDR_W-1:0]  req_addr_q, req_addr_d;
`ifdef FETCH_MISALIGN_CHECK_EN
  logic               misalign_q, misalign_d;
`endif

  logic               ld, hold, clr;
  logic [ADDR_W-1:0]  ld_pc;
  logic [INSTR_W-1:0] ld_instr;
  logic               req_block;
  logic               misaligned;
  logic               req_fire;

  always_comb begin
    state_d    = state_q;
    drop_d     = drop_q;
    skid_d     = skid_q;
    req_addr_d = req_addr_q;
`ifdef FETCH_MISALIGN_CHECK_EN
    misalign_d = misalign_q;
    req_block  = drop_q | misalign_q;
    misaligned = (pc[1:0] != 2'b00);
`else
    req_block  = drop_q;
    misaligned = 1'b0;
`endif
    pc_en          = 1'b0;
    ld             = 1'b0;
    hold           = stall;
    clr            = 1'b0;
    ld_pc          = req_addr_q;
    ld_instr       = imem_rsp_data;
    imem_req_valid = (state_q == REQ) && !req_block && !misaligned;
    imem_req_addr  = (state_q == REQ) ? pc : req_addr_q;
    req_fire       = imem_req_valid && imem_req_ready;

    case (state_q)
      IDLE: state_d = REQ;
      REQ: begin
        if (req_fire) begin
          state_d    = WAIT;
          req_addr_d = pc;
        end
`ifdef FETCH_MISALIGN_CHECK_EN
        else if (!req_block && misaligned) begin
          ld         = 1'b1;
          ld_pc      = pc;
          ld_instr   = NOP_INSTR;
          misalign_d = 1'b1;
        end
`endif
        // The response orphaned by an earlier flush lands here and is swallowed.
        if (drop_q && imem_rsp_valid) begin
          drop_d = 1'b0;
        end
      end
      WAIT: begin
        if (imem_rsp_valid) begin
          if (!stall) begin
            ld      = 1'b1;
            pc_en   = 1'b1;
            state_d = REQ;
          end else begin
            skid_d  = imem_rsp_data;
            state_d = HOLD;
          end
        end
      end
      HOLD: begin
        if (!stall) begin
          ld       = 1'b1;
          ld_instr = skid_q;
          pc_en    = 1'b1;
          state_d  = REQ;
        end
      end
      default: state_d = IDLE;
    endcase

`ifdef FETCH_MISALIGN_CHECK_EN
    if (misalign_q) begin
      hold = 1'b1;
    end
`endif

    // A request still in flight (or accepted this very cycle) will produce a
    // response after the redirect; mark it for discard.
    if (flush) begin
      state_d = REQ;
      pc_en   = 1'b1;
      clr     = 1'b1;
      ld      = 1'b0;
      skid_d  = '0;
`ifdef FETCH_MISALIGN_CHECK_EN
      misalign_d = 1'b0;
`endif
      if (((state_q == WAIT) && !imem_rsp_valid) || req_fire) begin
        drop_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      drop_q     <= 1'b0;
      skid_q     <= '0;
      req_addr_q <= '0;
`ifdef FETCH_MISALIGN_CHECK_EN
      misalign_q <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      drop_q     <= drop_d;
      skid_q     <= skid_d;
      req_addr_q <= req_addr_d;
`ifdef FETCH_MISALIGN_CHECK_EN
      misalign_q <= misalign_d;
`endif
    end
  end

`ifdef FETCH_MISALIGN_CHECK_EN
  assign misalign_err = misalign_q;
`endif

  if_id_reg u_if_id (
    .clk        (clk),
    .reset      (reset),
    .load       (ld),
    .hold       (hold),
    .clear      (clr),
    .load_pc    (ld_pc),
    .load_instr (ld_instr),
    .if_valid   (if_valid),
    .if_pc      (if_pc),
    .if_instr   (if_instr)
  );

endmodule
